// File: rtl/crc_pipe_if.sv
// Handshake bundle for crc_pipe_engine: message input side and CRC result output side.
interface crc_pipe_if #(
    parameter int P_WIDTH = 8,
    parameter int P_MSG_W = 32,
    parameter int P_TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [P_MSG_W-1:0] in_data;
    logic               in_check;
    logic [P_WIDTH-1:0] in_expect;
    logic [P_TAG_W-1:0] in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [P_WIDTH-1:0] out_crc;
    logic               out_match;
    logic [P_TAG_W-1:0] out_tag;
    logic               out_check;

    modport master (
        output in_valid, in_data, in_check, in_expect, in_tag, out_ready,
        input  in_ready, out_valid, out_crc, out_match, out_tag, out_check
    );

    modport slave (
        input  in_valid, in_data, in_check, in_expect, in_tag, out_ready,
        output in_ready, out_valid, out_crc, out_match, out_tag, out_check
    );
endinterface

// File: rtl/crc_pipe_engine.sv
// Pipelined CRC engine: one message per beat, P_BPS message bits folded per stage,
// elastic valid/ready pipeline whose bubbles collapse, optional expected-CRC check.
module crc_pipe_engine #(
    parameter int                 P_WIDTH   = 8,
    parameter logic [P_WIDTH-1:0] P_POLYNOM = 8'h31,
    parameter logic [P_WIDTH-1:0] P_INIT    = {P_WIDTH{1'b0}},
    parameter logic [P_WIDTH-1:0] P_XOROUT  = {P_WIDTH{1'b0}},
    parameter int                 P_MSG_W   = 32,
    parameter int                 P_BPS     = 4,
    parameter int                 P_TAG_W   = 4
) (
    input  logic      clk,
    input  logic      rstN,
    crc_pipe_if.slave bus
);
    localparam int N = P_MSG_W / P_BPS;

    if ((P_MSG_W % P_BPS) != 0) begin : g_bad_bps
        $error("crc_pipe_engine: P_MSG_W must be a multiple of P_BPS");
    end
    if ((P_WIDTH < 2) || (P_WIDTH > 32)) begin : g_bad_width
        $error("crc_pipe_engine: P_WIDTH must lie in 2..32");
    end

    // Fold P_BPS message bits into the CRC register, MSB first.
    function automatic logic [P_WIDTH-1:0] crc_steps(
        input logic [P_WIDTH-1:0] crc_in,
        input logic [P_BPS-1:0]   bits
    );
        logic [P_WIDTH-1:0] c;
        logic               fb;
        c = crc_in;
        for (int i = P_BPS - 1; i >= 0; i--) begin
            fb = c[P_WIDTH-1] ^ bits[i];
            c  = {c[P_WIDTH-2:0], 1'b0} ^ (fb ? P_POLYNOM : {P_WIDTH{1'b0}});
        end
        return c;
    endfunction

    logic [N-1:0]       valid_q, valid_d;
    logic [P_WIDTH-1:0] crc_q  [N];
    logic [P_WIDTH-1:0] crc_d  [N];
    logic [P_MSG_W-1:0] data_q [N];
    logic [P_MSG_W-1:0] data_d [N];
    logic [N-1:0]       chk_q, chk_d;
    logic [P_WIDTH-1:0] exp_q  [N];
    logic [P_WIDTH-1:0] exp_d  [N];
    logic [P_TAG_W-1:0] tag_q  [N];
    logic [P_TAG_W-1:0] tag_d  [N];
    logic               match_q, match_d;

    logic [N:0]         rdy_s;
    logic               in_ready_s;
    logic [N-1:0]       src_valid_s;
    logic [P_WIDTH-1:0] src_crc_s  [N];
    logic [P_MSG_W-1:0] src_data_s [N];
    logic [N-1:0]       src_chk_s;
    logic [P_WIDTH-1:0] src_exp_s  [N];
    logic [P_TAG_W-1:0] src_tag_s  [N];

    // Ready chain: a stage can take new content when it is empty or its successor moves on.
    always_comb begin
        logic rdy_v;
        rdy_v    = bus.out_ready;
        rdy_s    = {(N + 1){1'b0}};
        rdy_s[N] = rdy_v;
        for (int k = N - 1; k >= 0; k--) begin
            rdy_v    = !valid_q[k] || rdy_v;
            rdy_s[k] = rdy_v;
        end
    end

    assign in_ready_s = rstN && rdy_s[0];

    // Source of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid_s[0] = bus.in_valid && in_ready_s;
        src_crc_s[0]   = P_INIT;
        src_data_s[0]  = bus.in_data;
        src_chk_s[0]   = bus.in_check;
        src_exp_s[0]   = bus.in_expect;
        src_tag_s[0]   = bus.in_tag;
        for (int k = 1; k < N; k++) begin
            src_valid_s[k] = valid_q[k-1];
            src_crc_s[k]   = crc_q[k-1];
            src_data_s[k]  = data_q[k-1];
            src_chk_s[k]   = chk_q[k-1];
            src_exp_s[k]   = exp_q[k-1];
            src_tag_s[k]   = tag_q[k-1];
        end
    end

    // Stage next-state: advance when ready (bubbles collapse), otherwise hold everything.
    always_comb begin
        logic [P_WIDTH-1:0] step_crc;
        valid_d = valid_q;
        chk_d   = chk_q;
        for (int k = 0; k < N; k++) begin
            step_crc = crc_steps(src_crc_s[k], src_data_s[k][P_MSG_W-1 -: P_BPS]);
            if (rdy_s[k]) begin
                valid_d[k] = src_valid_s[k];
                crc_d[k]   = (k == N - 1) ? (step_crc ^ P_XOROUT) : step_crc;
                data_d[k]  = src_data_s[k] << P_BPS;
                chk_d[k]   = src_chk_s[k];
                exp_d[k]   = src_exp_s[k];
                tag_d[k]   = src_tag_s[k];
            end else begin
                valid_d[k] = valid_q[k];
                crc_d[k]   = crc_q[k];
                data_d[k]  = data_q[k];
                chk_d[k]   = chk_q[k];
                exp_d[k]   = exp_q[k];
                tag_d[k]   = tag_q[k];
            end
        end
        // Match follows the stored final-stage fields, so it holds whenever they hold.
        match_d = chk_d[N-1] && (crc_d[N-1] == exp_d[N-1]);
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            valid_q <= {N{1'b0}};
            chk_q   <= {N{1'b0}};
            match_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                crc_q[k]  <= {P_WIDTH{1'b0}};
                data_q[k] <= {P_MSG_W{1'b0}};
                exp_q[k]  <= {P_WIDTH{1'b0}};
                tag_q[k]  <= {P_TAG_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            chk_q   <= chk_d;
            match_q <= match_d;
            for (int k = 0; k < N; k++) begin
                crc_q[k]  <= crc_d[k];
                data_q[k] <= data_d[k];
                exp_q[k]  <= exp_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = valid_q[N-1];
    assign bus.out_crc   = crc_q[N-1];
    assign bus.out_match = match_q;
    assign bus.out_tag   = tag_q[N-1];
    assign bus.out_check = chk_q[N-1];
endmodule

// File: tb/tb_crc_pipe_engine.sv
// Self-checking bench for crc_pipe_engine: 32/4 streaming configuration with a scoreboard,
// 8/1 configuration driven from a vector table, and an 8/8 preset/xorout configuration.
module tb_crc_pipe_engine;
    localparam int NA = 8;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    crc_pipe_if #(.P_WIDTH(8), .P_MSG_W(32), .P_TAG_W(4)) a_if ();
    crc_pipe_if #(.P_WIDTH(8), .P_MSG_W(8),  .P_TAG_W(4)) b_if ();
    crc_pipe_if #(.P_WIDTH(8), .P_MSG_W(8),  .P_TAG_W(4)) c_if ();

    crc_pipe_engine u_a (.clk(clk), .rstN(rst_a_n), .bus(a_if));
    crc_pipe_engine #(.P_MSG_W(8), .P_BPS(1)) u_b (.clk(clk), .rstN(rst_b_n), .bus(b_if));
    crc_pipe_engine #(.P_INIT(8'hFF), .P_XOROUT(8'hFF), .P_MSG_W(8), .P_BPS(8))
        u_c (.clk(clk), .rstN(rst_c_n), .bus(c_if));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bitwise serial reference, polynomial 0x31, width 8.
    function automatic logic [7:0] ref_crc(input logic [31:0] d, input int nbits,
                                           input logic [7:0] init, input logic [7:0] xo);
        logic [7:0] c;
        logic       fb;
        c = init;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
        end
        return c ^ xo;
    endfunction

    typedef struct {
        logic [7:0] crc;
        logic       match;
        logic       chk;
        logic [3:0] tag;
    } exp_t;

    exp_t       q_a[$];
    int         occ_a = 0;
    logic [3:0] tag_a = 4'd0;
    logic       hold_a = 1'b0;
    logic [7:0] prev_crc = 8'h00;
    logic [3:0] prev_tag = 4'h0;
    logic       prev_match = 1'b0, prev_chk = 1'b0;

    // Scoreboard monitor for configuration A: ready model, hold stability, ordered results.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_a_n) begin
            occ_a  <= 0;
            hold_a <= 1'b0;
            q_a.delete();
        end else begin
            check("a_in_ready", 32'(a_if.in_ready), 32'(a_if.out_ready || (occ_a < NA)));
            if (hold_a) begin
                check("a_hold_valid", 32'(a_if.out_valid), 32'd1);
                check("a_hold_crc",   32'(a_if.out_crc),   32'(prev_crc));
                check("a_hold_tag",   32'(a_if.out_tag),   32'(prev_tag));
                check("a_hold_match", 32'(a_if.out_match), 32'(prev_match));
                check("a_hold_check", 32'(a_if.out_check), 32'(prev_chk));
            end
            if (a_if.out_valid && a_if.out_ready) begin
                check("a_out_expected", 32'(q_a.size() > 0), 32'd1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_crc",   32'(a_if.out_crc),   32'(e.crc));
                    check("a_tag",   32'(a_if.out_tag),   32'(e.tag));
                    check("a_match", 32'(a_if.out_match), 32'(e.match));
                    check("a_check", 32'(a_if.out_check), 32'(e.chk));
                end
            end
            occ_a      <= occ_a + int'(a_if.in_valid && a_if.in_ready) - int'(a_if.out_valid && a_if.out_ready);
            hold_a     <= a_if.out_valid && !a_if.out_ready;
            prev_crc   <= a_if.out_crc;
            prev_tag   <= a_if.out_tag;
            prev_match <= a_if.out_match;
            prev_chk   <= a_if.out_check;
        end
    end

    task automatic offer_a(output bit took);
        logic [31:0] d;
        logic        c;
        logic [7:0]  r, x;
        d = $urandom;
        c = 1'($urandom_range(0, 1));
        r = ref_crc(d, 32, 8'h00, 8'h00);
        x = ($urandom_range(0, 1) == 0) ? r : 8'($urandom);
        a_if.in_valid  = 1'b1;
        a_if.in_data   = d;
        a_if.in_check  = c;
        a_if.in_expect = x;
        a_if.in_tag    = tag_a;
        @(negedge clk);
        took = a_if.in_ready;
        if (took) begin
            q_a.push_back('{crc: r, match: (c && (r == x)), chk: c, tag: tag_a});
            tag_a = tag_a + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a();
        bit took;
        int n;
        took = 1'b0;
        n    = 0;
        while (!took && (n < 100)) begin
            offer_a(took);
            n++;
        end
        check("a_send_accepted", 32'(took), 32'd1);
    endtask

    task automatic drain_a();
        int n;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        n = 0;
        while ((q_a.size() > 0) && (n < 200)) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("a_drain_empty", 32'(q_a.size()), 32'd0);
    endtask

    // One message through configuration B: accept, latency of 8, result fields.
    task automatic run_b(input string name, input logic [7:0] d, input logic c,
                         input logic [7:0] x, input logic [3:0] t,
                         input logic [7:0] exp_crc, input logic exp_match);
        int c0, n;
        b_if.in_valid  = 1'b1;
        b_if.in_data   = d;
        b_if.in_check  = c;
        b_if.in_expect = x;
        b_if.in_tag    = t;
        c0 = cyc;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(b_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_if.out_valid && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(cyc - c0), 32'd8);
        check({name, "_crc"},     32'(b_if.out_crc),   32'(exp_crc));
        check({name, "_match"},   32'(b_if.out_match), 32'(exp_match));
        check({name, "_check"},   32'(b_if.out_check), 32'(c));
        check({name, "_tag"},     32'(b_if.out_tag),   32'(t));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       chk;
        logic [7:0] expv;
        logic [7:0] crc;
        logic       match;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int   c0, n, acc, vcount;
        bit   took;

        vt[0] = '{8'h01, 1'b0, 8'h00, 8'h31, 1'b0};
        vt[1] = '{8'h80, 1'b0, 8'h00, 8'h7A, 1'b0};
        vt[2] = '{8'h81, 1'b0, 8'h00, 8'h4B, 1'b0};
        vt[3] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vt[4] = '{8'h80, 1'b1, 8'h7A, 8'h7A, 1'b1};
        vt[5] = '{8'h80, 1'b1, 8'h7B, 8'h7A, 1'b0};
        vt[6] = '{8'h80, 1'b0, 8'h7A, 8'h7A, 1'b0};

        {a_if.in_valid, a_if.in_data, a_if.in_check, a_if.in_expect, a_if.in_tag} = '0;
        {b_if.in_valid, b_if.in_data, b_if.in_check, b_if.in_expect, b_if.in_tag} = '0;
        {c_if.in_valid, c_if.in_data, c_if.in_check, c_if.in_expect, c_if.in_tag} = '0;
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        c_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_crc",   32'(a_if.out_crc),   32'd0);
        check("rst_out_tag",   32'(a_if.out_tag),   32'd0);
        check("rst_out_match", 32'(a_if.out_match), 32'd0);
        check("rst_out_check", 32'(a_if.out_check), 32'd0);
        check("rst_in_ready",  32'(a_if.in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        rst_c_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(a_if.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Vector table on the 8-bit, 1-bit-per-stage configuration
        for (int i = 0; i < 7; i++)
            run_b($sformatf("b_vec%0d", i), vt[i].data, vt[i].chk, vt[i].expv, 4'(i),
                  vt[i].crc, vt[i].match);

        // 20 back-to-back messages: first result at cycle 8, contiguous output
        c0 = cyc;
        fork
            begin
                for (int i = 0; i < 20; i++) send_a();
                a_if.in_valid = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!a_if.out_valid && (n < 40)) begin
                    @(negedge clk);
                    n++;
                end
                check("a_first_latency", 32'(cyc - c0), 32'd8);
                vcount = 0;
                for (int i = 0; i < 19; i++) begin
                    @(negedge clk);
                    vcount += int'(a_if.out_valid);
                end
                check("a_contiguous", 32'(vcount), 32'd19);
            end
        join
        drain_a();

        // Output stalled for 15 cycles from an empty pipe
        a_if.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 15; i++) begin
            offer_a(took);
            acc += int'(took);
        end
        check("a_stall_accepts", 32'(acc), 32'(NA));
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_a();
        drain_a();

        // Random backpressure and random input gaps
        for (int i = 0; i < 120; i++) begin
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                offer_a(took);
            end else begin
                a_if.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain_a();

        // Reset with 5 messages in flight
        for (int i = 0; i < 5; i++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = 8'($urandom);
            b_if.in_tag   = 4'(i + 8);
            @(posedge clk);
            #1;
        end
        b_if.in_valid = 1'b0;
        rst_b_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_rst_out_valid", 32'(b_if.out_valid), 32'd0);
        check("b_rst_in_ready",  32'(b_if.in_ready),  32'd0);
        check("b_rst_out_tag",   32'(b_if.out_tag),   32'd0);
        @(posedge clk);
        #1;
        rst_b_n = 1'b1;
        @(negedge clk);
        check("b_rel_in_ready", 32'(b_if.in_ready), 32'd1);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vcount += int'(b_if.out_valid);
        end
        check("b_no_ghost_out", 32'(vcount), 32'd0);
        @(posedge clk);
        #1;
        run_b("b_after_rst", 8'h01, 1'b0, 8'h00, 4'h3, 8'h31, 1'b0);

        // Single-stage configuration with preset and output XOR
        c_if.in_valid = 1'b1;
        c_if.in_data  = 8'h00;
        c_if.in_tag   = 4'h5;
        c0 = cyc;
        @(posedge clk);
        #1;
        c_if.in_valid = 1'b0;
        @(negedge clk);
        check("c_out_valid", 32'(c_if.out_valid), 32'd1);
        check("c_latency",   32'(cyc - c0),       32'd1);
        check("c_crc",       32'(c_if.out_crc),   32'(ref_crc(32'h0, 8, 8'hFF, 8'hFF)));
        check("c_tag",       32'(c_if.out_tag),   32'h5);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
